// File: rtl/square_sequencer_if.sv
// Handshake/bus bundle between the frame timing source and the square sequencer.
// The master drives frame timing and user controls; the slave returns colour and size state.
interface square_sequencer_if;
  logic       frame_start;
  logic       step_btn;
  logic       auto_en;
  logic       anim_en;
  logic [9:0] size_req;
  logic [3:0] colour_state;
  logic [9:0] square_size;
  logic       grow_dir;

  modport master (
    output frame_start, step_btn, auto_en, anim_en, size_req,
    input  colour_state, square_size, grow_dir
  );

  modport slave (
    input  frame_start, step_btn, auto_en, anim_en, size_req,
    output colour_state, square_size, grow_dir
  );
endinterface

// File: rtl/square_sequencer.sv
// Colour-state FSM and square-size controller for the square-drawing pixel datapath.
// Every visible change commits on a frame_start cycle so a frame never tears.
module square_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES   = 50000,
  parameter int unsigned FRAMES_PER_COLOUR = 60,
  parameter int unsigned MIN_SIZE          = 1,
  parameter int unsigned MAX_SIZE          = 479,
  parameter int unsigned SIZE_STEP         = 4
) (
  input  logic              fsm_clck,
  input  logic              reset,
  square_sequencer_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int FC_W = (FRAMES_PER_COLOUR > 1) ? $clog2(FRAMES_PER_COLOUR) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_COLOUR - 1);

  localparam logic [10:0] MIN11  = 11'(MIN_SIZE);
  localparam logic [10:0] MAX11  = 11'(MAX_SIZE);
  localparam logic [10:0] STEP11 = 11'(SIZE_STEP);
  localparam logic [9:0]  MIN10  = 10'(MIN_SIZE);
  localparam logic [9:0]  MAX10  = 10'(MAX_SIZE);
  localparam logic [9:0]  STEP10 = 10'(SIZE_STEP);

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_RED   = 4'b1000;
  localparam logic [3:0] ST_GREEN = 4'b0100;
  localparam logic [3:0] ST_BLUE  = 4'b0010;

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            pending_q, pending_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]      colour_q, colour_d;
  logic [9:0]      size_q, size_d;
  logic            grow_q, grow_d;

  logic            step_pulse;
  logic            tick;
  logic            advance;
  logic [10:0]     size11;
  logic [10:0]     sum11;

  // Debounce: count consecutive cycles the synced level disagrees with the accepted one.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    stable_d   = stable_q;
    db_cnt_d   = '0;
    step_pulse = 1'b0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d   = sync2_q;
        step_pulse = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    tick        = 1'b0;
    if (!bus.auto_en) begin
      frame_cnt_d = '0;
    end else if (bus.frame_start) begin
      if (frame_cnt_q == FC_LAST) begin
        tick        = 1'b1;
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  // A step request and an auto tick on the same frame collapse into one advance.
  assign advance = pending_q | step_pulse | tick;

  always_comb begin
    colour_d  = colour_q;
    pending_d = pending_q | step_pulse;
    if (bus.frame_start) begin
      pending_d = 1'b0;
      case (colour_q)
        ST_IDLE:  if (advance) colour_d = ST_RED;
        ST_RED:   if (advance) colour_d = ST_GREEN;
        ST_GREEN: if (advance) colour_d = ST_BLUE;
        ST_BLUE:  if (advance) colour_d = ST_RED;
        default:  colour_d = ST_RED;
      endcase
    end
  end

  // Size arithmetic is carried in 11 bits so size+step never wraps past 1023.
  assign size11 = {1'b0, size_q};
  assign sum11  = size11 + STEP11;

  always_comb begin
    size_d = size_q;
    grow_d = grow_q;
    if (bus.frame_start) begin
      if (bus.anim_en) begin
        if (grow_q) begin
          if (sum11 >= MAX11) begin
            size_d = MAX10;
            grow_d = 1'b0;
          end else begin
            size_d = sum11[9:0];
          end
        end else if (size11 <= MIN11 + STEP11) begin
          size_d = MIN10;
          grow_d = 1'b1;
        end else begin
          size_d = size_q - STEP10;
        end
      end else if (bus.size_req < MIN10) begin
        size_d = MIN10;
      end else if (bus.size_req > MAX10) begin
        size_d = MAX10;
      end else begin
        size_d = bus.size_req;
      end
    end
  end

  always_ff @(posedge fsm_clck or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      stable_q    <= 1'b0;
      db_cnt_q    <= '0;
      pending_q   <= 1'b0;
      frame_cnt_q <= '0;
      colour_q    <= ST_IDLE;
      size_q      <= MIN10;
      grow_q      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values,
      // which is what makes sync1_q -> sync2_q a real two-stage synchroniser.
      sync1_q     <= bus.step_btn;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      db_cnt_q    <= db_cnt_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      colour_q    <= colour_d;
      size_q      <= size_d;
      grow_q      <= grow_d;
    end
  end

  assign bus.colour_state = colour_q;
  assign bus.square_size  = size_q;
  assign bus.grow_dir     = grow_q;

endmodule

// File: tb/tb_square_sequencer.sv
// Self-checking bench for square_sequencer: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a behavioural model.
module tb_square_sequencer;

  localparam int DB   = 4;
  localparam int FPC  = 3;
  localparam int MINS = 1;
  localparam int MAXS = 20;
  localparam int STEP = 8;

  localparam logic [3:0] C_IDLE  = 4'b0001;
  localparam logic [3:0] C_RED   = 4'b1000;
  localparam logic [3:0] C_GREEN = 4'b0100;

  logic clk = 1'b0;
  logic rst;

  square_sequencer_if sif();

  square_sequencer #(
    .DEBOUNCE_CYCLES  (DB),
    .FRAMES_PER_COLOUR(FPC),
    .MIN_SIZE         (MINS),
    .MAX_SIZE         (MAXS),
    .SIZE_STEP        (STEP)
  ) dut (
    .fsm_clck(clk),
    .reset   (rst),
    .bus     (sif.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_col(input string name, input logic [3:0] exp);
    check(name, int'(sif.colour_state), int'(exp));
  endtask

  task automatic check_all(input string name, input logic [3:0] ec,
                           input logic [9:0] es, input logic eg);
    check({name, "_colour"}, int'(sif.colour_state), int'(ec));
    check({name, "_size"},   int'(sif.square_size),  int'(es));
    check({name, "_grow"},   int'(sif.grow_dir),     int'(eg));
  endtask

  // Behavioural reference: colour as an index 0=IDLE 1=RED 2=GREEN 3=BLUE.
  int m_colour, m_size, m_fcnt, m_run;
  bit m_grow, m_pend, m_s1, m_s2, m_stable;

  function automatic logic [3:0] onehot(input int idx);
    case (idx)
      0:       return 4'b0001;
      1:       return 4'b1000;
      2:       return 4'b0100;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic model_step();
    bit press, tick;
    if (rst) begin
      m_colour = 0; m_size = MINS; m_grow = 1; m_pend = 0; m_fcnt = 0;
      m_run = 0; m_s1 = 0; m_s2 = 0; m_stable = 0;
      return;
    end
    press = 0;
    if (m_s2 != m_stable) begin
      m_run++;
      if (m_run == DB) begin
        m_stable = m_s2;
        m_run    = 0;
        press    = m_s2;
      end
    end else begin
      m_run = 0;
    end
    tick = sif.auto_en && sif.frame_start && (m_fcnt == FPC - 1);
    if (!sif.auto_en) m_fcnt = 0;
    else if (sif.frame_start) m_fcnt = (m_fcnt + 1) % FPC;
    if (sif.frame_start) begin
      if (m_pend || press || tick) m_colour = (m_colour % 3) + 1;
      m_pend = 0;
      if (sif.anim_en) begin
        if (m_grow) begin
          if (m_size + STEP >= MAXS) begin m_size = MAXS; m_grow = 0; end
          else m_size = m_size + STEP;
        end else if (m_size <= MINS + STEP) begin
          m_size = MINS; m_grow = 1;
        end else begin
          m_size = m_size - STEP;
        end
      end else begin
        m_size = (int'(sif.size_req) < MINS) ? MINS :
                 (int'(sif.size_req) > MAXS) ? MAXS : int'(sif.size_req);
      end
    end else begin
      m_pend = m_pend | press;
    end
    m_s2 = m_s1;
    m_s1 = sif.step_btn;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fs, input logic btn, input logic auto_v,
                       input logic anim, input logic [9:0] req);
    sif.frame_start = fs;
    sif.step_btn    = btn;
    sif.auto_en     = auto_v;
    sif.anim_en     = anim;
    sif.size_req    = req;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 10'd0);
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       fs;
    logic       anim;
    logic [9:0] req;
    logic [9:0] e_size;
    logic       e_grow;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 10'd0,    10'd1,  1'b1};
    tbl[1]  = '{1'b1, 1'b0, 10'd25,   10'd20, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 10'd10,   10'd10, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 10'd1,    10'd1,  1'b1};
    tbl[4]  = '{1'b1, 1'b1, 10'd0,    10'd9,  1'b1};
    tbl[5]  = '{1'b1, 1'b1, 10'd0,    10'd17, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 10'd0,    10'd20, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 10'd0,    10'd12, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 10'd0,    10'd4,  1'b0};
    tbl[9]  = '{1'b1, 1'b1, 10'd0,    10'd1,  1'b1};
    tbl[10] = '{1'b1, 1'b0, 10'd300,  10'd20, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 10'd0,    10'd20, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 10'd5,    10'd20, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 10'd5,    10'd5,  1'b0};
    tbl[14] = '{1'b1, 1'b1, 10'd0,    10'd1,  1'b1};
    tbl[15] = '{1'b1, 1'b0, 10'd1023, 10'd20, 1'b1};

    do_reset();
    check_all("reset", C_IDLE, 10'(MINS), 1'b1);

    // Size table: manual clamp, bounce animation and its turning points.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].fs, 0, 0, tbl[i].anim, tbl[i].req);
      cycle();
      check_all($sformatf("size_vec%0d", i), C_IDLE, tbl[i].e_size, tbl[i].e_grow);
    end

    // Exact step latency; a pulse coinciding with frame_start is consumed at once.
    do_reset();
    drive(0, 1, 0, 0, 10'd1);
    repeat (4) cycle();
    drive(1, 1, 0, 0, 10'd1);
    cycle();
    check_col("early_frame", C_IDLE);
    cycle();
    check_col("same_cycle_consume", C_RED);
    cycle();
    check_col("consumed_once", C_RED);

    // Clean press held 10 cycles, then one frame_start.
    do_reset();
    drive(0, 1, 0, 0, 10'd1);
    repeat (10) cycle();
    check_col("press_before_frame", C_IDLE);
    drive(1, 1, 0, 0, 10'd1);
    cycle();
    check_col("press_at_frame", C_RED);
    drive(0, 0, 0, 0, 10'd1);
    repeat (10) cycle();
    drive(1, 0, 0, 0, 10'd1);
    cycle();
    check_col("release_no_step", C_RED);
    for (int r = 0; r < 4; r++) begin
      drive(0, 1, 0, 0, 10'd1);
      repeat (2) cycle();
      drive(0, 0, 0, 0, 10'd1);
      repeat (2) cycle();
    end
    repeat (8) cycle();
    drive(1, 0, 0, 0, 10'd1);
    cycle();
    check_col("bounce_ignored", C_RED);

    // Auto stepping every third frame.
    do_reset();
    for (int p = 1; p <= 7; p++) begin
      drive(1, 0, 1, 0, 10'd1);
      cycle();
      check_col($sformatf("auto_pulse%0d", p),
                (p < 3) ? C_IDLE : (p < 6) ? C_RED : C_GREEN);
      drive(0, 0, 1, 0, 10'd1);
      repeat (2) cycle();
    end

    // Pending press and auto tick on the same frame advance only once.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      drive(1, 0, 1, 0, 10'd1);
      cycle();
      drive(0, 0, 1, 0, 10'd1);
      cycle();
    end
    drive(0, 1, 1, 0, 10'd1);
    repeat (10) cycle();
    drive(1, 0, 1, 0, 10'd1);
    cycle();
    check_col("pend_plus_tick", C_RED);
    drive(0, 0, 1, 0, 10'd1);
    cycle();
    drive(1, 0, 1, 0, 10'd1);
    cycle();
    check_col("no_double_step", C_RED);

    // Illegal encoding recovers to RED on the next frame_start.
    drive(0, 0, 0, 0, 10'd1);
    force dut.colour_q = 4'b0011;
    cycle();
    release dut.colour_q;
    check_col("illegal_holds", 4'b0011);
    drive(1, 0, 0, 0, 10'd1);
    cycle();
    check_col("illegal_recover", C_RED);

    // Reset in the middle of a debounce discards the press.
    drive(1, 0, 0, 0, 10'd10);
    cycle();
    drive(0, 1, 0, 0, 10'd10);
    repeat (4) cycle();
    rst = 1'b1;
    #1;
    check_all("async_reset", C_IDLE, 10'(MINS), 1'b1);
    drive(0, 0, 0, 0, 10'd1);
    repeat (2) cycle();
    rst = 1'b0;
    repeat (10) cycle();
    drive(1, 0, 0, 0, 10'd1);
    cycle();
    check_col("no_step_after_reset", C_IDLE);

    // Randomized run against the reference model.
    do_reset();
    drive(0, 0, 0, 0, 10'd0);
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 599) == 0);
      sif.frame_start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) sif.step_btn = ~sif.step_btn;
      if ($urandom_range(0, 49) == 0) sif.auto_en = ~sif.auto_en;
      if ($urandom_range(0, 39) == 0) sif.anim_en = ~sif.anim_en;
      sif.size_req = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                                  : 10'($urandom_range(0, 30));
      cycle();
      check("rand_colour", int'(sif.colour_state), int'(onehot(m_colour)));
      check("rand_size",   int'(sif.square_size),  m_size);
      check("rand_grow",   int'(sif.grow_dir),     int'(m_grow));
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
